// File: rtl/pc_select_reg.sv
`default_nettype none
// ============================================================================
// Module      : pc_select_reg
// Description : Registered program-counter source selector for the IF stage.
//               Picks the next PC from NUM_SRC candidates using fixed-priority
//               redirect requests. The highest index wins. Source 0 is the
//               sequential path. Holds on stall or when disabled. A redirect
//               seen during a stall is captured and applied on release.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_select_reg #(
    parameter int                    PC_SIZE  = 32,
    parameter int                    NUM_SRC  = 4,
    parameter int                    SEL_SIZE = $clog2(NUM_SRC),
    parameter logic [PC_SIZE-1:0]    RESET_PC = '0
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_enable,
    input  logic                        i_stall,
    input  logic [NUM_SRC-1:0]          i_req,
    input  logic [NUM_SRC*PC_SIZE-1:0]  i_src,
    output logic [PC_SIZE-1:0]          o_pc,
    output logic [SEL_SIZE-1:0]         o_sel,
    output logic                        o_pending,
    output logic                        o_redirect
);

    logic [PC_SIZE-1:0]  r_pc;
    logic [SEL_SIZE-1:0] r_sel;
    logic                r_redirect;
    logic                r_pending;
    logic [PC_SIZE-1:0]  r_pend_pc;
    logic [SEL_SIZE-1:0] r_pend_idx;

    logic                w_live_valid;
    logic [SEL_SIZE-1:0] w_live_idx;
    logic [PC_SIZE-1:0]  w_live_pc;
    logic                w_update;
    logic                w_use_pend;
    logic                w_capture;
    logic [SEL_SIZE-1:0] w_cand_idx;
    logic [PC_SIZE-1:0]  w_cand_pc;

    // Live winner: highest requesting index >= 1. Bit 0 of i_req is ignored,
    // so with no request the winner falls back to the sequential source 0.
    always_comb begin
        w_live_valid = 1'b0;
        w_live_idx   = '0;
        w_live_pc    = i_src[0 +: PC_SIZE];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (i_req[k]) begin
                w_live_valid = 1'b1;
                w_live_idx   = SEL_SIZE'(k);
                w_live_pc    = i_src[k*PC_SIZE +: PC_SIZE];
            end
        end
    end

    // Arbitration between the live winner and the captured entry. A tie goes
    // to the live request so that a fresh target value replaces a stale one.
    always_comb begin
        w_update   = i_enable & ~i_stall;
        w_use_pend = r_pending & (r_pend_idx > w_live_idx);
        w_cand_idx = w_use_pend ? r_pend_idx : w_live_idx;
        w_cand_pc  = w_use_pend ? r_pend_pc  : w_live_pc;
        w_capture  = i_enable & i_stall & w_live_valid &
                     (~r_pending | (w_live_idx >= r_pend_idx));
    end

    // State update. o_redirect is a pulse that is cleared by default and set
    // only by a redirecting update. Disabled cycles freeze everything else.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_sel      <= '0;
            r_redirect <= 1'b0;
            r_pending  <= 1'b0;
            r_pend_pc  <= '0;
            r_pend_idx <= '0;
        end else begin
            r_redirect <= 1'b0;
            if (w_update) begin
                r_pc       <= w_cand_pc;
                r_sel      <= w_cand_idx;
                r_redirect <= (w_cand_idx != '0);
                r_pending  <= 1'b0;
            end else if (w_capture) begin
                r_pending  <= 1'b1;
                r_pend_pc  <= w_live_pc;
                r_pend_idx <= w_live_idx;
            end
        end
    end

    assign o_pc       = r_pc;
    assign o_sel      = r_sel;
    assign o_pending  = r_pending;
    assign o_redirect = r_redirect;

endmodule
`default_nettype wire

// File: tb/tb_pc_select_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_select_reg
// Description : Directed self-checking bench for pc_select_reg. Each
//               comparison checks {pc, sel, pending, redirect} together.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_select_reg;

    localparam int PC_SIZE  = 32;
    localparam int NUM_SRC  = 4;
    localparam int SEL_SIZE = 2;

    logic                        clk;
    logic                        rst;
    logic                        enable;
    logic                        stall;
    logic [NUM_SRC-1:0]          req;
    logic [NUM_SRC*PC_SIZE-1:0]  src;
    logic [PC_SIZE-1:0]          pc;
    logic [SEL_SIZE-1:0]         sel;
    logic                        pending;
    logic                        redirect;

    int tests;
    int fails;

    pc_select_reg #(
        .PC_SIZE  (PC_SIZE),
        .NUM_SRC  (NUM_SRC),
        .RESET_PC (32'h0)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_enable   (enable),
        .i_stall    (stall),
        .i_req      (req),
        .i_src      (src),
        .o_pc       (pc),
        .o_sel      (sel),
        .o_pending  (pending),
        .o_redirect (redirect)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and sample just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int k, input logic [PC_SIZE-1:0] v);
        src[k*PC_SIZE +: PC_SIZE] = v;
    endtask

    task automatic test_reset();
        logic [35:0] exp;
        rst = 1'b1; enable = 1'b1; stall = 1'b0; req = '0; src = '0;
        step();
        step();
        exp = {32'h0, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL reset: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [35:0] exp;
        set_src(0, 32'h4);
        step();
        exp = {32'h4, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL seq_4: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        set_src(0, 32'h8);
        step();
        exp = {32'h8, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL seq_8: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
    endtask

    task automatic test_priority();
        logic [35:0] exp;
        req = 4'b1010; set_src(1, 32'h100); set_src(3, 32'h300);
        step();
        exp = {32'h300, 2'd3, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL prio_hi: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        req = '0; set_src(0, 32'h304);
        step();
        exp = {32'h304, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL redirect_pulse: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
    endtask

    task automatic test_stall_capture();
        logic [35:0] exp;
        stall = 1'b1; req = 4'b0010; set_src(1, 32'h200); set_src(0, 32'h308);
        step();
        req = '0;
        exp = {32'h304, 2'd0, 1'b1, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL stall_cap: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        step();
        step();
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL stall_hold: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        stall = 1'b0;
        step();
        exp = {32'h200, 2'd1, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL stall_release: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
    endtask

    task automatic test_pending_priority();
        logic [35:0] exp;
        // Lower-priority request must not displace the pending entry.
        stall = 1'b1; req = 4'b0100; set_src(2, 32'h240);
        step();
        req = 4'b0010; set_src(1, 32'h120);
        step();
        req = '0; stall = 1'b0;
        step();
        exp = {32'h240, 2'd2, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL pend_no_overwrite: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        // Higher-priority request replaces it.
        stall = 1'b1; req = 4'b0100;
        step();
        req = 4'b1000; set_src(3, 32'h380);
        step();
        req = '0; stall = 1'b0;
        step();
        exp = {32'h380, 2'd3, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL pend_overwrite: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
    endtask

    task automatic test_tie();
        logic [35:0] exp;
        stall = 1'b1; req = 4'b0100; set_src(2, 32'h240);
        step();
        stall = 1'b0; req = 4'b0100; set_src(2, 32'h500);
        step();
        exp = {32'h500, 2'd2, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL tie_live: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        stall = 1'b1; req = 4'b0100; set_src(2, 32'h240);
        step();
        stall = 1'b0; req = 4'b0010; set_src(1, 32'h150); set_src(2, 32'h999);
        step();
        exp = {32'h240, 2'd2, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL pend_beats_lower: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        req = '0;
    endtask

    task automatic test_reset_pending();
        logic [35:0] exp;
        stall = 1'b1; req = 4'b1000; set_src(3, 32'h3c0);
        step();
        req = '0; rst = 1'b1;
        step();
        exp = {32'h0, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL reset_pend: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        rst = 1'b0; stall = 1'b0; set_src(0, 32'h10);
        step();
        exp = {32'h10, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL after_reset: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
    endtask

    task automatic test_disable();
        logic [35:0] exp;
        enable = 1'b0; req = 4'b1000; set_src(3, 32'habc); set_src(0, 32'h14);
        step();
        exp = {32'h10, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL disable_hold: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        enable = 1'b1; req = '0;
        step();
        exp = {32'h14, 2'd0, 1'b0, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL disable_nocap: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        // Pending entry survives a disabled cycle, even with stall low.
        stall = 1'b1; req = 4'b0010; set_src(1, 32'h1a0);
        step();
        enable = 1'b0; stall = 1'b0; req = '0;
        step();
        exp = {32'h14, 2'd0, 1'b1, 1'b0};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL disable_keep_pend: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
        enable = 1'b1;
        step();
        exp = {32'h1a0, 2'd1, 1'b0, 1'b1};
        tests++;
        if ({pc, sel, pending, redirect} !== exp) begin
            fails++;
            $display("FAIL disable_then_apply: got pc=%h sel=%0d pend=%b red=%b want %h", pc, sel, pending, redirect, exp);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; enable = 1'b0; stall = 1'b0; req = '0; src = '0;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_capture();
        test_pending_priority();
        test_tie();
        test_reset_pending();
        test_disable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
